// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with one-bubble redirect and stall hold register
// Optional retired/cycle counters are enabled by defining IF_STAGE_PERF_CNT_EN.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        should_br,
  input  logic [31:0] ALU_result,
  input  logic [31:0] fetch_data,
  output logic [31:0] fetch_addr,
  output logic [31:0] PC,
  output logic [31:0] instruction_EXE,
  output logic [31:0] cycle_cnt,
  output logic [31:0] inst_cnt
);

  logic [31:0] pc_if;
  logic [31:0] pc_ex;
  logic [31:0] hold_reg;
  logic        boot_q;
  logic        kill_q;
  logic        hold_valid;
  logic [6:0]  opcode;
  logic        jump;
  logic        redirect;
  logic [31:0] target;

  assign opcode   = instruction_EXE[6:0];
  assign jump     = (instruction_EXE != 32'h0) &&
                    ((opcode == 7'b1101111) || (opcode == 7'b1100111));
  assign redirect = !stall && (should_br || jump);
  assign target   = ALU_result & 32'hFFFF_FFFE;

  assign fetch_addr = pc_if;
  assign PC         = pc_ex;

  // The hold register wins because fetch_data moves on to pc_if's word during a stall.
  always_comb begin
    if (hold_valid)
      instruction_EXE = hold_reg;
    else if (boot_q || kill_q)
      instruction_EXE = 32'h0;
    else
      instruction_EXE = fetch_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_if      <= RESET_PC;
      pc_ex      <= 32'h0;
      boot_q     <= 1'b1;
      kill_q     <= 1'b0;
      hold_valid <= 1'b0;
      hold_reg   <= 32'h0;
    end else if (!stall) begin
      pc_ex      <= pc_if;
      pc_if      <= redirect ? target : pc_if + 32'd4;
      kill_q     <= redirect;
      boot_q     <= 1'b0;
      hold_valid <= 1'b0;
    end else if (!hold_valid) begin
      hold_valid <= 1'b1;
      hold_reg   <= instruction_EXE;
    end
  end

`ifdef IF_STAGE_PERF_CNT_EN
  logic [31:0] cycle_q;
  logic [31:0] inst_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_q <= 32'h0;
      inst_q  <= 32'h0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (!stall && (instruction_EXE != 32'h0))
        inst_q <= inst_q + 32'd1;
    end
  end

  assign cycle_cnt = cycle_q;
  assign inst_cnt  = inst_q;
`else
  assign cycle_cnt = 32'h0;
  assign inst_cnt  = 32'h0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed vector table plus randomized run against a fetch-stage model
module tb_if_stage;

  localparam logic [31:0] B = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        should_br;
  logic [31:0] ALU_result;
  logic [31:0] fetch_data = 32'h0;
  logic [31:0] fetch_addr;
  logic [31:0] PC;
  logic [31:0] instruction_EXE;
  logic [31:0] cycle_cnt;
  logic [31:0] inst_cnt;

  int checks = 0;
  int errors = 0;
  bit jump_mix = 1'b0;

  if_stage #(.RESET_PC(B)) dut (
    .clk(clk), .rst(rst), .stall(stall), .should_br(should_br),
    .ALU_result(ALU_result), .fetch_data(fetch_data), .fetch_addr(fetch_addr),
    .PC(PC), .instruction_EXE(instruction_EXE), .cycle_cnt(cycle_cnt), .inst_cnt(inst_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] h;
    logic [6:0]  opc;
    if (a == 32'h4000_0104) return 32'h0000_006F;
    if (a == 32'h4000_0204) return 32'h00A0_0093;
    h = a * 32'h9E37_79B1;
    h = h ^ (h >> 15);
    opc = 7'h13;
    if (jump_mix && h[4:2] == 3'd0) opc = 7'h6F;
    else if (jump_mix && h[4:2] == 3'd1) opc = 7'h67;
    return {h[31:7], opc};
  endfunction

  // Synchronous-read instruction memory: data for last cycle's address.
  always @(posedge clk) fetch_data <= mem_word(fetch_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        st;
    logic        br;
    logic [31:0] alu;
    logic [31:0] fa;
    logic [31:0] pc;
    logic [31:0] ins;
  } vec_t;

  function automatic vec_t v(input logic st, input logic br, input logic [31:0] alu,
                             input logic [31:0] fa, input logic [31:0] pc, input logic [31:0] ins);
    vec_t r;
    r.st = st; r.br = br; r.alu = alu; r.fa = fa; r.pc = pc; r.ins = ins;
    return r;
  endfunction

  function automatic bit is_jump(input logic [31:0] ins);
    return (ins != 0) && (ins[6:0] == 7'h6F || ins[6:0] == 7'h67);
  endfunction

  vec_t tbl[23];

  logic [31:0] m_fetch, m_expc, exp_ins, m_ccnt, m_icnt;
  bit          m_bub, taken;
  logic        r_st, r_br;
  logic [31:0] r_alu;

  initial begin
    rst = 1'b0; stall = 1'b0; should_br = 1'b0; ALU_result = 32'h0;

    tbl[0]  = v(0, 0, 0,        B,         0,         0);
    tbl[1]  = v(0, 0, 0,        B+4,       B,         mem_word(B));
    tbl[2]  = v(0, 0, 0,        B+8,       B+4,       mem_word(B+4));
    tbl[3]  = v(0, 0, 0,        B+'hC,     B+8,       mem_word(B+8));
    tbl[4]  = v(0, 0, 0,        B+'h10,    B+'hC,     mem_word(B+'hC));
    tbl[5]  = v(0, 1, B+'h101,  B+'h14,    B+'h10,    mem_word(B+'h10));
    tbl[6]  = v(0, 0, 0,        B+'h100,   B+'h14,    0);
    tbl[7]  = v(0, 0, 0,        B+'h104,   B+'h100,   mem_word(B+'h100));
    tbl[8]  = v(0, 0, B+'h200,  B+'h108,   B+'h104,   32'h0000_006F);
    tbl[9]  = v(0, 0, 0,        B+'h200,   B+'h108,   0);
    tbl[10] = v(0, 0, 0,        B+'h204,   B+'h200,   mem_word(B+'h200));
    tbl[11] = v(1, 0, 0,        B+'h208,   B+'h204,   32'h00A0_0093);
    tbl[12] = v(1, 1, B+'h900,  B+'h208,   B+'h204,   32'h00A0_0093);
    tbl[13] = v(1, 0, 0,        B+'h208,   B+'h204,   32'h00A0_0093);
    tbl[14] = v(0, 0, 0,        B+'h208,   B+'h204,   32'h00A0_0093);
    tbl[15] = v(0, 1, B+'h300,  B+'h20C,   B+'h208,   mem_word(B+'h208));
    tbl[16] = v(1, 1, B+'h800,  B+'h300,   B+'h20C,   0);
    tbl[17] = v(1, 0, 0,        B+'h300,   B+'h20C,   0);
    tbl[18] = v(0, 0, 0,        B+'h300,   B+'h20C,   0);
    tbl[19] = v(0, 0, 0,        B+'h304,   B+'h300,   mem_word(B+'h300));
    tbl[20] = v(1, 0, 0,        B+'h308,   B+'h304,   mem_word(B+'h304));
    tbl[21] = v(1, 0, 0,        B+'h308,   B+'h304,   mem_word(B+'h304));
    tbl[22] = v(1, 0, 0,        B+'h308,   B+'h304,   mem_word(B+'h304));

    @(negedge clk);
    chk("reset_fa", fetch_addr, B);
    chk("reset_pc", PC, 32'h0);
    chk("reset_ins", instruction_EXE, 32'h0);
    chk("reset_ccnt", cycle_cnt, 32'h0);
    chk("reset_icnt", inst_cnt, 32'h0);
    rst = 1'b1;

    for (int i = 0; i < 23; i++) begin
      stall = tbl[i].st; should_br = tbl[i].br; ALU_result = tbl[i].alu;
      chk($sformatf("row%0d_fa", i), fetch_addr, tbl[i].fa);
      chk($sformatf("row%0d_pc", i), PC, tbl[i].pc);
      chk($sformatf("row%0d_ins", i), instruction_EXE, tbl[i].ins);
      @(negedge clk);
    end

    // Still stalled with the hold register full; reset must clear it with no clock edge.
    chk("hold_before_rst", instruction_EXE, mem_word(B+'h304));
    #2 rst = 1'b0;
    #1;
    chk("midrst_fa", fetch_addr, B);
    chk("midrst_pc", PC, 32'h0);
    chk("midrst_ins", instruction_EXE, 32'h0);
    chk("midrst_ccnt", cycle_cnt, 32'h0);
    chk("midrst_icnt", inst_cnt, 32'h0);
    @(negedge clk);
    stall = 1'b0; should_br = 1'b0; ALU_result = 32'h0;
    rst = 1'b1;
    chk("rel_ins", instruction_EXE, 32'h0);
    repeat (10) @(negedge clk);
    chk("free_fa", fetch_addr, B+'h28);
    chk("free_pc", PC, B+'h24);
`ifdef IF_STAGE_PERF_CNT_EN
    chk("free_ccnt", cycle_cnt, 32'd10);
    chk("free_icnt", inst_cnt, 32'd9);
`else
    chk("free_ccnt", cycle_cnt, 32'd0);
    chk("free_icnt", inst_cnt, 32'd0);
`endif

    // Randomized run: EX holds the word at its PC unless it is a bubble.
    rst = 1'b0; jump_mix = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    m_fetch = B; m_expc = 32'h0; m_bub = 1'b1; m_ccnt = 0; m_icnt = 0;
    for (int n = 0; n < 3000; n++) begin
      exp_ins = m_bub ? 32'h0 : mem_word(m_expc);
      chk("rnd_fa", fetch_addr, m_fetch);
      chk("rnd_pc", PC, m_expc);
      chk("rnd_ins", instruction_EXE, exp_ins);
`ifdef IF_STAGE_PERF_CNT_EN
      chk("rnd_ccnt", cycle_cnt, m_ccnt);
      chk("rnd_icnt", inst_cnt, m_icnt);
`endif
      r_st  = ($urandom_range(3) == 0);
      r_br  = ($urandom_range(6) == 0);
      r_alu = ($urandom_range(15) == 0) ? 32'hFFFF_FFF9 : $urandom;
      stall = r_st; should_br = r_br; ALU_result = r_alu;
      @(posedge clk);
      m_ccnt = m_ccnt + 1;
      if (!r_st) begin
        taken = r_br || is_jump(exp_ins);
        if (exp_ins != 0) m_icnt = m_icnt + 1;
        m_expc  = m_fetch;
        m_bub   = taken;
        m_fetch = taken ? {r_alu[31:1], 1'b0} : m_fetch + 32'd4;
      end
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h4000_0000, first fetch address after reset.
REQ-002 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- stall  in  1  hold fetch and EX contents this cycle.
- should_br  in  1  conditional branch taken, from EX.
- ALU_result  in  32  redirect target computed in EX.
- fetch_data  in  32  synchronous-read instruction memory data for the address presented the previous cycle.
- fetch_addr  out  32  fetch PC driven to instruction memory.
- PC  out  32  PC of the instruction in EX.
- instruction_EXE  out  32  instruction in EX; 32'h0 = bubble.
- cycle_cnt  out  32  cycle counter.
- inst_cnt  out  32  retired-instruction counter.

Function
REQ-003 SHALL hold registers pc_if (drives fetch_addr), pc_ex (drives PC), boot_q, kill_q, hold_valid and hold_reg[31:0].
REQ-004 SHALL decode jump = instruction_EXE != 0 and opcode [6:0] equal to 7'b1101111 (JAL) or 7'b1100111 (JALR).
REQ-005 SHALL define redirect = !stall and (should_br or jump).
REQ-006 SHALL define target = {ALU_result[31:1], 1'b0}.
REQ-007 SHALL drive instruction_EXE combinationally, first match wins:
- hold_valid: hold_reg.
- boot_q or kill_q: 32'h0.
- otherwise: fetch_data.
REQ-008 SHALL, on an edge with stall=0:
- pc_ex <= pc_if.
- pc_if <= target if redirect, else pc_if+4.
- kill_q <= redirect.
- boot_q <= 0.
- hold_valid <= 0.
REQ-009 SHALL, on an edge with stall=1, hold pc_if, pc_ex, kill_q and boot_q.
REQ-010 SHALL, on an edge with stall=1 and hold_valid=0, set hold_valid <= 1 and hold_reg <= instruction_EXE.
REQ-011 SHALL leave hold_reg unchanged while hold_valid=1.
REQ-012 SHALL ignore should_br and jump while stall=1; EX re-presents them after the stall releases.
REQ-013 SHALL have a taken-redirect penalty of exactly one bubble: the instruction at target appears on instruction_EXE two cycles after the redirect cycle.
REQ-014 SHALL compute pc_if+4 and the counters modulo 2^32, with silent wrap.
REQ-015 SHALL keep fetch_addr stable throughout a stall, so that fetch_data is correct in the first unstalled cycle after release.

Reset
REQ-016 SHALL, while rst=0, immediately and asynchronously set:
- pc_if = RESET_PC, pc_ex = 0.
- boot_q = 1, kill_q = 0, hold_valid = 0, hold_reg = 0.
- cycle_cnt = 0, inst_cnt = 0.
REQ-017 SHALL therefore output instruction_EXE = 0 during reset and in the first cycle after release.
REQ-018 SHALL abandon any in-progress stall, hold or pending kill on reset assertion mid-operation, with no residual state.

Configuration
REQ-019 SHALL, with IF_STAGE_PERF_CNT_EN defined:
- increment cycle_cnt every edge with rst=1.
- increment inst_cnt on edges where stall=0 and instruction_EXE != 0.
REQ-020 SHALL, without IF_STAGE_PERF_CNT_EN, keep both counter ports present and tied to 32'h0, with no counter flops.

Verification
REQ-021 Reset release, stall=0, fetch_data = mem[fetch_addr] one cycle late -> cycle0 fetch_addr=4000_0000, instruction_EXE=0; cycle1 PC=4000_0000, instruction_EXE=mem[4000_0000]; cycle2 fetch_addr=4000_0008.
REQ-022 Branch in EX at PC=4000_0010, should_br=1, ALU_result=4000_0101 -> next cycle fetch_addr=4000_0100, instruction_EXE=0; following cycle PC=4000_0100 with its instruction.
REQ-023 JAL (opcode 6F) in EX, should_br=0, ALU_result=4000_0200 -> one bubble, then PC=4000_0200.
REQ-024 stall=1 for 3 cycles with instruction 0x00A00093 in EX -> instruction_EXE=0x00A00093 and fetch_addr constant for all 3 cycles plus the release cycle; next instruction follows without loss or duplication.
REQ-025 Stall asserted in the bubble cycle after a redirect -> instruction_EXE stays 0 for the whole stall; target instruction appears after release.
REQ-026 rst pulsed low mid-stall with hold_valid=1 -> all outputs return to reset values asynchronously. With IF_STAGE_PERF_CNT_EN, after 10 free-running cycles (1 boot bubble) -> cycle_cnt=10, inst_cnt=9.
